// File: rtl/fetch_queue_wide.sv
// fetch_queue_wide: multi-lane in-order {PC, instruction} queue between fetch and decode.
// Up to LANES entries are accepted and up to LANES oldest entries are presented per cycle.
// Reads are show-ahead, so deq_data depends only on registered state.
// A redirect flushes the whole queue.
// An enqueue group that does not fit is dropped whole and latched in overflow_err.
module fetch_queue_wide #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 8,
  parameter int LANES    = 2,
  parameter int AFULL_TH = 6
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         flush,
  input  logic [$clog2(LANES+1)-1:0]   enq_count,
  input  logic [LANES*WIDTH-1:0]       enq_data,
  output logic                         enq_ready,
  input  logic [$clog2(LANES+1)-1:0]   deq_req,
  output logic [LANES*WIDTH-1:0]       deq_data,
  output logic [LANES-1:0]             deq_valid,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_full,
  output logic                         overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int CNT_W = $clog2(LANES+1);
  localparam int EXT_W = OCC_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [OCC_W-1:0] occCount;
  logic             overflowFlag;

  logic [EXT_W-1:0] freeSlots;
  logic [EXT_W-1:0] enqExt;
  logic [EXT_W-1:0] deqExt;
  logic [EXT_W-1:0] grantDeq;
  logic [EXT_W-1:0] acceptEnq;
  logic             enqFits;

  // Grant/accept decisions; free space is taken before this cycle's dequeue
  always_comb begin
    freeSlots = EXT_W'(DEPTH) - EXT_W'(occCount);
    enqExt    = EXT_W'(enq_count);
    deqExt    = EXT_W'(deq_req);
    grantDeq  = (deqExt < EXT_W'(occCount)) ? deqExt : EXT_W'(occCount);
    enqFits   = (enqExt <= freeSlots);
    acceptEnq = enqFits ? enqExt : '0;
  end

  // Pointer, occupancy and sticky overflow state; flush wins over enq/deq
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      headPtr      <= '0;
      tailPtr      <= '0;
      occCount     <= '0;
      overflowFlag <= 1'b0;
    end else begin
      overflowFlag <= overflowFlag | ~enqFits;
      if (flush) begin
        headPtr  <= '0;
        tailPtr  <= '0;
        occCount <= '0;
      end else begin
        headPtr  <= headPtr + PTR_W'(grantDeq);
        tailPtr  <= tailPtr + PTR_W'(acceptEnq);
        occCount <= OCC_W'(EXT_W'(occCount) + acceptEnq - grantDeq);
      end
    end
  end

  // Entry storage write; lanes land at consecutive slots from tail, wrapping naturally
  always_ff @(posedge CLK) begin
    for (int i = 0; i < LANES; i++) begin
      if (!flush && enqFits && (CNT_W'(i) < enq_count)) begin
        mem[tailPtr + PTR_W'(i)] <= enq_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Show-ahead read of the LANES oldest entries plus per-lane valid
  always_comb begin
    deq_data  = '0;
    deq_valid = '0;
    for (int i = 0; i < LANES; i++) begin
      deq_data[i*WIDTH +: WIDTH] = mem[headPtr + PTR_W'(i)];
      deq_valid[i]               = (EXT_W'(occCount) > EXT_W'(i));
    end
  end

  assign occupancy    = occCount;
  assign empty        = (occCount == '0);
  assign full         = (occCount == OCC_W'(DEPTH));
  assign almost_full  = (EXT_W'(occCount) >= EXT_W'(AFULL_TH));
  assign enq_ready    = (freeSlots >= EXT_W'(LANES));
  assign overflow_err = overflowFlag;

  // Lane counts beyond LANES are illegal requests from fetch/decode
  assert property (@(posedge CLK) disable iff (RESET) enq_count <= CNT_W'(LANES));
  assert property (@(posedge CLK) disable iff (RESET) deq_req <= CNT_W'(LANES));

endmodule

// File: tb/tb_fetch_queue_wide.sv
// Bench for fetch_queue_wide: directed scenarios followed by random traffic.
// A queue-based reference model supplies every expected value.
module tb_fetch_queue_wide;

  localparam int WIDTH    = 64;
  localparam int DEPTH    = 8;
  localparam int LANES    = 2;
  localparam int AFULL_TH = 6;
  localparam int CW       = $clog2(LANES+1);
  localparam int OW       = $clog2(DEPTH+1);

  logic                   CLK = 1'b0;
  logic                   RESET;
  logic                   flush;
  logic [CW-1:0]          enq_count;
  logic [LANES*WIDTH-1:0] enq_data;
  logic                   enq_ready;
  logic [CW-1:0]          deq_req;
  logic [LANES*WIDTH-1:0] deq_data;
  logic [LANES-1:0]       deq_valid;
  logic [OW-1:0]          occupancy;
  logic                   empty;
  logic                   full;
  logic                   almost_full;
  logic                   overflow_err;

  fetch_queue_wide #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES), .AFULL_TH(AFULL_TH)) dut (
    .CLK(CLK), .RESET(RESET), .flush(flush),
    .enq_count(enq_count), .enq_data(enq_data), .enq_ready(enq_ready),
    .deq_req(deq_req), .deq_data(deq_data), .deq_valid(deq_valid),
    .occupancy(occupancy), .empty(empty), .full(full),
    .almost_full(almost_full), .overflow_err(overflow_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] q[$];
  logic ovfModel = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's current contents
  task automatic checkOutputs(input string tag);
    int n;
    logic [LANES-1:0] expVld;
    n = q.size();
    expVld = '0;
    for (int i = 0; i < LANES; i++) expVld[i] = (n > i);
    chk({tag, ".occupancy"}, 64'(occupancy), 64'(n));
    chk({tag, ".empty"}, 64'(empty), 64'(n == 0));
    chk({tag, ".full"}, 64'(full), 64'(n == DEPTH));
    chk({tag, ".almost_full"}, 64'(almost_full), 64'(n >= AFULL_TH));
    chk({tag, ".enq_ready"}, 64'(enq_ready), 64'((DEPTH - n) >= LANES));
    chk({tag, ".deq_valid"}, 64'(deq_valid), 64'(expVld));
    chk({tag, ".overflow_err"}, 64'(overflow_err), 64'(ovfModel));
    for (int i = 0; i < LANES; i++)
      if (i < n) chk($sformatf("%s.lane%0d", tag, i), deq_data[i*WIDTH +: WIDTH], q[i]);
  endtask

  // Model of one clock edge: flush clears, else dequeue min(req,count), then
  // append the group only if it fits in the space free before the dequeue
  task automatic modelEdge(input logic fl, input int ec, input logic [LANES*WIDTH-1:0] ed, input int dr);
    int n;
    int freeN;
    int g;
    n = q.size();
    freeN = DEPTH - n;
    g = (dr < n) ? dr : n;
    if (ec > freeN) ovfModel = 1'b1;
    if (fl) begin
      q.delete();
    end else begin
      repeat (g) void'(q.pop_front());
      if (ec <= freeN)
        for (int i = 0; i < ec; i++) q.push_back(ed[i*WIDTH +: WIDTH]);
    end
  endtask

  task automatic idleInputs();
    flush = 1'b0;
    enq_count = '0;
    deq_req = '0;
    enq_data = '0;
  endtask

  // One cycle: drive at negedge, check model state, apply edge, return inputs to idle
  task automatic step(input string tag, input logic fl, input int ec,
                      input logic [LANES*WIDTH-1:0] ed, input int dr);
    @(negedge CLK);
    flush = fl;
    enq_count = CW'(ec);
    enq_data = ed;
    deq_req = CW'(dr);
    #1;
    checkOutputs(tag);
    @(posedge CLK);
    modelEdge(fl, ec, ed, dr);
    #1;
    idleInputs();
  endtask

  task automatic idleCheck(input string tag);
    @(negedge CLK);
    #1;
    checkOutputs(tag);
  endtask

  function automatic logic [LANES*WIDTH-1:0] rndData();
    logic [LANES*WIDTH-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*WIDTH +: WIDTH] = {$urandom, $urandom};
    return d;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LANES*WIDTH-1:0] d;
    // Reset then idle
    RESET = 1'b1;
    idleInputs();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst.empty", 64'(empty), 64'd1);
    chk("rst.enq_ready", 64'(enq_ready), 64'd1);
    chk("rst.deq_valid", 64'(deq_valid), 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    idleCheck("idle");
    chk("idle.occupancy", 64'(occupancy), 64'd0);
    chk("idle.overflow_err", 64'(overflow_err), 64'd0);

    // Fill with 1..8, then drain in pairs
    for (int k = 0; k < 4; k++)
      step("fill", 1'b0, 2, {64'(2*k+2), 64'(2*k+1)}, 0);
    idleCheck("filled");
    chk("filled.full", 64'(full), 64'd1);
    chk("filled.enq_ready", 64'(enq_ready), 64'd0);
    chk("filled.almost_full", 64'(almost_full), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      #1;
      chk("drain.lane0", deq_data[63:0], 64'(2*k+1));
      chk("drain.lane1", deq_data[127:64], 64'(2*k+2));
      step("drain", 1'b0, 0, '0, 2);
    end
    idleCheck("drained");
    chk("drained.empty", 64'(empty), 64'd1);

    // Wrap with uneven rates
    for (int k = 0; k < 3; k++) step("wrapPre", 1'b0, 1, 128'(32'h100 + k), 0);
    step("wrapPre", 1'b0, 0, '0, 2);
    step("wrapPre", 1'b0, 0, '0, 1);
    for (int c = 0; c < 20; c++) begin
      if (c % 2 == 0) step("wrap", 1'b0, ((DEPTH - q.size()) >= 2) ? 2 : 0, rndData(), 0);
      else            step("wrap", 1'b0, 0, '0, 1);
    end
    for (int k = 0; k < 8; k++) step("wrapDrain", 1'b0, 0, '0, 2);
    idleCheck("wrapEnd");

    // Overflow drop at occupancy 7 with same-cycle dequeue
    for (int k = 0; k < 3; k++) step("ovfFill", 1'b0, 2, rndData(), 0);
    step("ovfFill", 1'b0, 1, rndData(), 0);
    step("ovf", 1'b0, 2, rndData(), 2);
    idleCheck("ovfAfter");
    chk("ovf.overflow_err", 64'(overflow_err), 64'd1);
    chk("ovf.occupancy", 64'(occupancy), 64'd5);
    step("ovfFlush", 1'b1, 0, '0, 0);
    idleCheck("ovfFlushed");
    chk("ovfFlush.overflow_err", 64'(overflow_err), 64'd1);
    chk("ovfFlush.occupancy", 64'(occupancy), 64'd0);

    // Flush priority over enqueue and dequeue
    step("fpFill", 1'b0, 2, rndData(), 0);
    step("fpFill", 1'b0, 2, rndData(), 0);
    step("fp", 1'b1, 2, rndData(), 1);
    idleCheck("fpAfter");
    chk("fp.occupancy", 64'(occupancy), 64'd0);
    chk("fp.empty", 64'(empty), 64'd1);
    step("fpEnq", 1'b0, 1, 128'h0000ABCD, 0);
    idleCheck("fpEnqAfter");
    chk("fpEnq.deq_valid", 64'(deq_valid), 64'd1);
    chk("fpEnq.lane0", deq_data[63:0], 64'h0000ABCD);
    step("fpDrain", 1'b0, 0, '0, 1);

    // Asynchronous reset between edges
    step("arFill", 1'b0, 2, rndData(), 0);
    step("arFill", 1'b0, 2, rndData(), 0);
    step("arFill", 1'b0, 1, rndData(), 0);
    #2;
    RESET = 1'b1;
    #1;
    chk("ar.occupancy", 64'(occupancy), 64'd0);
    chk("ar.empty", 64'(empty), 64'd1);
    chk("ar.deq_valid", 64'(deq_valid), 64'd0);
    chk("ar.overflow_err", 64'(overflow_err), 64'd0);
    q.delete();
    ovfModel = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    d = {64'h22, 64'h11};
    step("arEnq", 1'b0, 2, d, 0);
    idleCheck("arEnqAfter");
    chk("arEnq.lane0", deq_data[63:0], 64'h11);
    chk("arEnq.lane1", deq_data[127:64], 64'h22);

    // Random traffic against the model
    for (int c = 0; c < 300; c++)
      step("rand", ($urandom_range(0, 15) == 0), $urandom_range(0, LANES), rndData(), $urandom_range(0, LANES));
    idleCheck("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue_wide.md
Name: fetch_queue_wide

Overview:
Parametrised, multi-lane in-order instruction queue that decouples fetch from decode. It replaces the single-lane 8x64 fetch queue. Each cycle it accepts up to LANES {PC, instruction} entries from fetch and presents up to LANES oldest entries to decode. It also provides branch-redirect flush, occupancy reporting and an almost-full backpressure hint.

Parameters:
WIDTH, 64, bits per entry ({PC[31:0], Instr[31:0]} by default)
DEPTH, 8, number of entries; power of two, >= 2*LANES
LANES, 2, maximum entries enqueued or dequeued per cycle (1..4)
AFULL_TH, 6, occupancy at or above which almost_full asserts (<= DEPTH)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
flush  in  1  discard all contents (branch redirect / Request_Alt_PC)
enq_count  in  $clog2(LANES+1)  number of valid lanes offered this cycle (0..LANES)
enq_data  in  LANES*WIDTH  lane i at [i*WIDTH +: WIDTH]; lane 0 oldest
enq_ready  out  1  free entries >= LANES
deq_req  in  $clog2(LANES+1)  number of entries decode consumes this cycle (0..LANES)
deq_data  out  LANES*WIDTH  lane i = (i)th oldest entry; lane 0 = head
deq_valid  out  LANES  bit i set iff occupancy > i
occupancy  out  $clog2(DEPTH+1)  current entry count
empty  out  1  occupancy == 0
full  out  1  occupancy == DEPTH
almost_full  out  1  occupancy >= AFULL_TH
overflow_err  out  1  sticky: an enqueue was dropped

Behaviour:
- Storage: DEPTH x WIDTH register array. Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The occupancy register is separate, so full and empty are unambiguous.
- Reset (async, RESET=1): head=0, tail=0, occupancy=0, overflow_err=0. Outputs during reset: empty=1, full=0, almost_full=0, enq_ready=1, deq_valid=0. deq_data content is don't-care; the bench must not check it. Array contents are not cleared.
- Show-ahead read: deq_data lane i = mem[(head+i) mod DEPTH], combinational from registered state. deq_valid is combinational from occupancy. There is no input-to-output combinational path.
- Dequeue: granted deq = min(deq_req, occupancy). Head advances by the granted count at the clock edge. A deq_req above occupancy is not an error; only the valid entries are consumed.
- Enqueue: free = DEPTH - occupancy, measured before this cycle's dequeue. Space freed by a same-cycle dequeue is not reusable in that cycle.
  - If enq_count <= free: lanes 0..enq_count-1 are written to mem[(tail+i) mod DEPTH] and tail advances by enq_count.
  - If enq_count > free: the whole group is dropped (no partial write), tail is unchanged, and overflow_err sets until reset.
- Occupancy next = occupancy + accepted_enq - granted_deq, all in the same cycle.
- Empty-queue bypass: none. An entry enqueued in cycle N is first visible on deq_data/deq_valid in cycle N+1. Latency is 1 cycle.
- Flush (synchronous, sampled at the edge): head=tail=0 and occupancy=0. Flush has priority over enq and deq in the same cycle, so same-cycle enqueue data is discarded. overflow_err is not cleared by flush.
- Wrap-around: multi-lane writes and reads that straddle index DEPTH-1 -> 0 must be correct for every head/tail alignment.
- enq_count or deq_req > LANES: illegal. Assertion in simulation; RTL behaviour undefined.

Test Plan:
- Reset then idle: RESET high 3 cycles, release -> empty=1, enq_ready=1, occupancy=0, deq_valid=2'b00, overflow_err=0.
- Fill/drain ordering (LANES=2, DEPTH=8): enq_count=2 for 4 cycles with entries 0x1..0x8 -> full=1, enq_ready=0, almost_full=1. Then deq_req=2 for 4 cycles -> pairs (1,2), (3,4), (5,6), (7,8) on lanes (0,1); ends empty.
- Wrap and uneven rates: enq 3 single-lane, deq 3, then enqueue 2/cycle alternating with deq_req=1 for 20 cycles -> scoreboard order exact across the 7->0 wrap; occupancy matches model every cycle.
- Overflow drop: occupancy=7, enq_count=2 with deq_req=2 in same cycle -> enqueue dropped, overflow_err=1, occupancy=5. Then flush -> overflow_err remains 1.
- Flush priority: occupancy=4, flush=1 with enq_count=2 and deq_req=1 -> next cycle occupancy=0, empty=1. Next enqueue appears at lane 0 one cycle later.
- Async reset mid-operation: assert RESET between edges with occupancy=5 -> empty=1 and occupancy=0 immediately (before the next edge). After release the queue operates from head=0.
